// File: rtl/crypto1_pkg.sv
// Shared crypto1 definitions: filter sub-functions, their preimage tables,
// enumerator state encoding and candidate-count constants.
package crypto1_pkg;

    localparam logic [15:0] FA_FN = 16'hF22C;
    localparam logic [15:0] FB_FN = 16'hD938;

    localparam int NUM_NIBBLES    = 5;
    localparam int IDX_W          = 3 * NUM_NIBBLES;
    localparam int NUM_CANDIDATES = 32768;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CANDIDATES - 1);

    // Entry [k] is the k-th smallest nibble value giving the named output.
    typedef logic [7:0][3:0] ptab_t;
    localparam ptab_t TBL_FA0 = {4'd11, 4'd10, 4'd8,  4'd7,  4'd6,  4'd4,  4'd1,  4'd0};
    localparam ptab_t TBL_FA1 = {4'd15, 4'd14, 4'd13, 4'd12, 4'd9,  4'd5,  4'd3,  4'd2};
    localparam ptab_t TBL_FB0 = {4'd13, 4'd10, 4'd9,  4'd7,  4'd6,  4'd2,  4'd1,  4'd0};
    localparam ptab_t TBL_FB1 = {4'd15, 4'd14, 4'd12, 4'd11, 4'd8,  4'd5,  4'd4,  4'd3};

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
    typedef enum logic {FSEL_FA = 1'b0, FSEL_FB = 1'b1} fsel_t;

endpackage

// File: rtl/crypto1_nibble_preimage.sv
// Combinational lookup: digit-th nibble value whose fa/fb output equals req_bit.
module crypto1_nibble_preimage
    import crypto1_pkg::*;
(
    input  fsel_t       fsel,
    input  logic        req_bit,
    input  logic [2:0]  digit,
    output logic [3:0]  nibble
);

    always_comb begin
        nibble = 4'd0;
        case ({fsel, req_bit})
            {FSEL_FA, 1'b0}: nibble = TBL_FA0[digit];
            {FSEL_FA, 1'b1}: nibble = TBL_FA1[digit];
            {FSEL_FB, 1'b0}: nibble = TBL_FB0[digit];
            {FSEL_FB, 1'b1}: nibble = TBL_FB1[digit];
            default:         nibble = 4'd0;
        endcase
    end

endmodule

// File: rtl/crypto1_filter_preimage_enum.sv
// Enumerates all 32768 20-bit filter inputs matching a 5-bit Fc input pattern,
// one candidate per handshake, with abort and valid/ready backpressure.
module crypto1_filter_preimage_enum
    import crypto1_pkg::*;
(
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        PAT_VALID,
    input  logic [4:0]  PAT,
    output logic        PAT_READY,
    input  logic        ABORT,
    output logic        OUT_VALID,
    output logic [19:0] OUT_DATA,
    output logic        OUT_LAST,
    input  logic        OUT_READY
);

    state_t             state_q, state_d;
    logic [4:0]         pat_q, pat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [19:0]        out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [19:0]        cand;

    // Candidate is built from the next-cycle pattern/index so OUT_DATA is a flop.
    for (genvar i = 0; i < NUM_NIBBLES; i++) begin : g_nib
        localparam fsel_t FSEL = (i == 1 || i == 4) ? FSEL_FB : FSEL_FA;
        crypto1_nibble_preimage u_pre (
            .fsel    (FSEL),
            .req_bit (pat_d[4-i]),
            .digit   (idx_d[3*i +: 3]),
            .nibble  (cand[4*i +: 4])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            pat_q      <= '0;
            idx_q      <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (PAT_VALID) begin
                    state_d = ST_RUN;
                    pat_d   = PAT;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                // A beat handshaken alongside ABORT is delivered; nothing follows it.
                if (ABORT || (OUT_READY && out_last_q))
                    state_d = ST_IDLE;
                else if (OUT_READY)
                    idx_d = idx_q + IDX_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        out_data_d = cand;
        out_last_d = (state_d == ST_RUN) && (idx_d == IDX_LAST);
    end

    always_comb begin
        PAT_READY = (state_q == ST_IDLE);
        OUT_VALID = (state_q == ST_RUN);
        OUT_DATA  = out_data_q;
        OUT_LAST  = out_last_q;
    end

endmodule

// File: tb/tb_crypto1_filter_preimage_enum.sv
// Scoreboard bench for the filter preimage enumerator.
module tb_crypto1_filter_preimage_enum;

    localparam logic [15:0] FA = 16'hF22C;
    localparam logic [15:0] FB = 16'hD938;
    localparam int NCAND = 32768;

    logic        CLK = 1'b0;
    logic        RESETn, PAT_VALID, ABORT, OUT_READY;
    logic [4:0]  PAT;
    logic        PAT_READY, OUT_VALID, OUT_LAST;
    logic [19:0] OUT_DATA;

    typedef struct {
        logic [4:0]  pat;
        int          idx;
        logic [19:0] data;
        logic        last;
    } sb_t;

    sb_t sbq[$];
    int  n_vec = 0, n_err = 0;
    int  cyc = 0, last_cyc = 0, n_acc = 0, pat_beats = 0;

    crypto1_filter_preimage_enum dut (
        .CLK(CLK), .RESETn(RESETn), .PAT_VALID(PAT_VALID), .PAT(PAT),
        .PAT_READY(PAT_READY), .ABORT(ABORT), .OUT_VALID(OUT_VALID),
        .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST), .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // d-th smallest nibble n with f[n] == b, found by scanning the truth table.
    function automatic logic [3:0] mnib(input logic [15:0] f, input logic b, input int d);
        int k = 0;
        for (int n = 0; n < 16; n++)
            if (f[n] == b) begin
                if (k == d) return 4'(n);
                k++;
            end
        return 4'd0;
    endfunction

    function automatic logic [19:0] mcand(input logic [4:0] p, input int idx);
        logic [19:0] r = '0;
        for (int i = 0; i < 5; i++)
            r[4*i +: 4] = mnib((i == 1 || i == 4) ? FB : FA, p[4-i], (idx >> (3*i)) & 7);
        return r;
    endfunction

    function automatic logic [4:0] fbits(input logic [19:0] d);
        logic [4:0] r;
        for (int i = 0; i < 5; i++)
            r[4-i] = ((i == 1 || i == 4) ? FB : FA) >> d[4*i +: 4];
        return r;
    endfunction

    task automatic push_pattern(input logic [4:0] p);
        sb_t e;
        for (int k = 0; k < NCAND; k++) begin
            e.pat  = p;
            e.idx  = k;
            e.data = mcand(p, k);
            e.last = (k == NCAND - 1);
            sbq.push_back(e);
        end
    endtask

    // One clock: decide OUT_READY, score any handshake, advance, check hold.
    task automatic step(input logic rdy);
        sb_t e;
        logic hs, acc, stall, hl;
        logic [19:0] hd;
        OUT_READY = rdy;
        hs    = RESETn && OUT_VALID && rdy;
        acc   = RESETn && PAT_VALID && PAT_READY;
        stall = RESETn && OUT_VALID && !rdy && !ABORT;
        hd    = OUT_DATA;
        hl    = OUT_LAST;
        if (hs) begin
            if (sbq.size() == 0) chk("extra_beat", 1, 0);
            else begin
                e = sbq.pop_front();
                pat_beats++;
                chk("data", OUT_DATA, e.data);
                chk("last", OUT_LAST, e.last);
                chk("fbits", fbits(OUT_DATA), e.pat);
                if (e.pat == 5'b00000 && e.idx == 0)         chk("zero_first", OUT_DATA, 20'h00000);
                if (e.pat == 5'b00000 && e.idx == NCAND - 1) chk("zero_last", OUT_DATA, 20'hDBBDB);
                if (e.pat == 5'b11111 && e.idx == 0)         chk("ones_b0", OUT_DATA, 20'h32232);
                if (e.pat == 5'b11111 && e.idx == 1)         chk("ones_b1", OUT_DATA, 20'h32233);
                if (e.last) begin
                    chk("beat_count", pat_beats, NCAND);
                    last_cyc = cyc;
                end
            end
        end
        if (acc) begin
            n_acc++;
            if (n_acc == 2) begin
                chk("b2b_gap", cyc - last_cyc, 1);
                chk("b2b_idle_valid", OUT_VALID, 0);
            end
            push_pattern(PAT);
            pat_beats = 0;
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (acc) begin
            chk("lat_valid", OUT_VALID, 1);
            chk("lat_ready", PAT_READY, 0);
        end
        if (stall && OUT_VALID) begin
            chk("hold_data", OUT_DATA, hd);
            chk("hold_last", OUT_LAST, hl);
        end
    endtask

    initial begin
        int guard;
        RESETn = 1'b0; PAT_VALID = 1'b0; PAT = '0; ABORT = 1'b0; OUT_READY = 1'b0;
        @(posedge CLK); #1;
        step(0); step(0);
        chk("rst_pat_ready", PAT_READY, 1);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_out_last", OUT_LAST, 0);
        chk("rst_out_data", OUT_DATA, 0);
        RESETn = 1'b1;
        step(0);

        // All-zero pattern under random backpressure; all-ones held waiting behind it.
        PAT_VALID = 1'b1; PAT = 5'b00000;
        step(1'($urandom_range(0, 99) < 80));
        PAT = 5'b11111;
        guard = 0;
        while (n_acc < 2 && guard < 60000) begin
            step(1'($urandom_range(0, 99) < 80));
            guard++;
        end
        if (guard >= 60000) chk("timeout_b2b", 0, 1);
        PAT_VALID = 1'b0;
        guard = 0;
        while ((OUT_VALID || sbq.size() != 0) && guard < 40000) begin
            step(1);
            guard++;
        end
        if (guard >= 40000) chk("timeout_ones", 0, 1);
        chk("ones_done_ready", PAT_READY, 1);
        sbq.delete();

        // Abort at beat 100 with downstream ready.
        PAT_VALID = 1'b1; PAT = 5'b10101;
        step(1);
        PAT_VALID = 1'b0;
        guard = 0;
        while (!(sbq.size() > 0 && sbq[0].idx == 100) && guard < 1000) begin
            step(1);
            guard++;
        end
        if (guard >= 1000) chk("timeout_abort", 0, 1);
        ABORT = 1'b1;
        step(1);
        ABORT = 1'b0;
        chk("abort_beats", pat_beats, 101);
        chk("abort_valid", OUT_VALID, 0);
        chk("abort_ready", PAT_READY, 1);
        sbq.delete();
        step(1);
        chk("abort_no_beat", OUT_VALID, 0);

        // ABORT coinciding with acceptance in IDLE is ignored; restart from index 0.
        PAT_VALID = 1'b1; PAT = 5'b01101; ABORT = 1'b1;
        step(0);
        PAT_VALID = 1'b0; ABORT = 1'b0;
        for (int k = 0; k < 5; k++) step(1);
        chk("restart_beats", pat_beats, 5);
        ABORT = 1'b1;
        step(0);
        ABORT = 1'b0;
        sbq.delete();

        // Reset asserted in the middle of an enumeration.
        PAT_VALID = 1'b1; PAT = 5'b01010;
        step(1);
        PAT_VALID = 1'b0;
        guard = 0;
        while (!(sbq.size() > 0 && sbq[0].idx == 500) && guard < 2000) begin
            step(1);
            guard++;
        end
        if (guard >= 2000) chk("timeout_reset", 0, 1);
        RESETn = 1'b0;
        step(1);
        chk("mrst_valid", OUT_VALID, 0);
        chk("mrst_last", OUT_LAST, 0);
        chk("mrst_data", OUT_DATA, 0);
        chk("mrst_ready", PAT_READY, 1);
        sbq.delete();
        RESETn = 1'b1;
        step(0);
        chk("mrst_ready_after", PAT_READY, 1);
        chk("mrst_valid_after", OUT_VALID, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
